// File: rtl/hub75_pkg.sv
// Shared definitions for the HUB75 frame buffer and the scan controller that consumes it.
package hub75_pkg;

   localparam int HUB75_COLS      = 32;
   localparam int HUB75_ROW_PAIRS = 16;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      CLEAR     = 2'd1,
      WAIT_SWAP = 2'd2
   } fb_state_t;

   typedef logic [2:0] rgb3_t;

   // Bit positions inside a read word {R0,G0,B0,R1,G1,B1}
   localparam int RD_R0 = 5;
   localparam int RD_G0 = 4;
   localparam int RD_B0 = 3;
   localparam int RD_R1 = 2;
   localparam int RD_G1 = 1;
   localparam int RD_B1 = 0;

   // Upper-half pixel occupies the high three bits, lower-half pixel the low three
   function automatic logic [5:0] pack_pair(input rgb3_t upper, input rgb3_t lower);
      return {upper, lower};
   endfunction

endpackage

// File: rtl/fb_sdp_ram.sv
// Simple dual-port pixel RAM: one write port, one registered read port.
module fb_sdp_ram
   import hub75_pkg::*;
#(
   parameter int DEPTH  = HUB75_ROW_PAIRS * HUB75_COLS,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  rgb3_t             wdata,
   input  logic              re,
   input  logic [ADDR_W-1:0] raddr,
   output rgb3_t             rdata
);

   rgb3_t mem [DEPTH];

   // Write port; contents are deliberately left unreset
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   // Registered read that holds its value while re is low; only the output register resets
   always_ff @(posedge clk) begin
      if (rst) begin
         rdata <= '0;
      end else if (re) begin
         rdata <= mem[raddr];
      end
   end

endmodule

// File: rtl/hub75_frame_buffer.sv
// Ping-pong pixel store feeding the HUB75 scanner; banks swap only at a frame boundary.
module hub75_frame_buffer
   import hub75_pkg::*;
#(
   parameter int COLS      = HUB75_COLS,
   parameter int ROW_PAIRS = HUB75_ROW_PAIRS,
   parameter int COL_W     = $clog2(COLS),
   parameter int ROW_W     = $clog2(ROW_PAIRS)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_valid,
   output logic             wr_ready,
   input  logic [COL_W-1:0] wr_x,
   input  logic [ROW_W:0]   wr_y,
   input  logic [2:0]       wr_rgb,
   input  logic             commit,
   input  logic             clear,
   output logic             swap_pending,
   output logic             clear_busy,
   input  logic             rd_en,
   input  logic [ROW_W-1:0] rd_row,
   input  logic [COL_W-1:0] rd_col,
   output logic [5:0]       rd_data,
   input  logic             frame_done,
   output logic             front_sel
);

   localparam int ADDR_W = ROW_W + COL_W;
   localparam int DEPTH  = ROW_PAIRS * COLS;
   localparam logic [ADDR_W-1:0] LAST_INDEX = ADDR_W'(DEPTH - 1);

   fb_state_t         state;
   logic [ADDR_W-1:0] clear_index;
   logic              rd_bank;
   logic              wr_xfer;
   logic              clearing;
   logic              back_sel;
   logic              up_we;
   logic              lo_we;
   logic [ADDR_W-1:0] wr_addr;
   logic [ADDR_W-1:0] rd_addr;
   rgb3_t             wr_word;
   rgb3_t             up_q [2];
   rgb3_t             lo_q [2];

   assign wr_ready = (state == IDLE);
   assign wr_xfer  = wr_valid && wr_ready;
   assign clearing = (state == CLEAR);
   assign back_sel = ~front_sel;

   // The clear sweep and pixel writes never overlap because writes are only accepted in IDLE
   assign wr_addr = clearing ? clear_index : {wr_y[ROW_W-1:0], wr_x};
   assign wr_word = clearing ? rgb3_t'(0) : rgb3_t'(wr_rgb);
   assign up_we   = clearing || (wr_xfer && !wr_y[ROW_W]);
   assign lo_we   = clearing || (wr_xfer &&  wr_y[ROW_W]);
   assign rd_addr = {rd_row, rd_col};

   generate
      for (genvar b = 0; b < 2; b++) begin : g_bank
         logic is_back;
         assign is_back = (back_sel == 1'(b));

         fb_sdp_ram #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_upper (
            .clk   (clk),
            .rst   (rst),
            .we    (up_we && is_back),
            .waddr (wr_addr),
            .wdata (wr_word),
            .re    (rd_en),
            .raddr (rd_addr),
            .rdata (up_q[b])
         );

         fb_sdp_ram #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_lower (
            .clk   (clk),
            .rst   (rst),
            .we    (lo_we && is_back),
            .waddr (wr_addr),
            .wdata (wr_word),
            .re    (rd_en),
            .raddr (rd_addr),
            .rdata (lo_q[b])
         );
      end
   endgenerate

   // Remember which bank was front when the read was issued so a swap on that edge doesn't leak into it
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_bank <= 1'b0;
      end else if (rd_en) begin
         rd_bank <= front_sel;
      end
   end

   assign rd_data = pack_pair(up_q[rd_bank], lo_q[rd_bank]);

   // Control FSM: clear sweep of the back bank, and commit/frame_done bank swap
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         front_sel    <= 1'b0;
         swap_pending <= 1'b0;
         clear_busy   <= 1'b0;
         clear_index  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (clear) begin
                  state       <= CLEAR;
                  clear_index <= '0;
                  clear_busy  <= 1'b1;
               end else if (commit) begin
                  state        <= WAIT_SWAP;
                  swap_pending <= 1'b1;
               end
            end
            CLEAR: begin
               clear_index <= clear_index + ADDR_W'(1);
               if (clear_index == LAST_INDEX) begin
                  state      <= IDLE;
                  clear_busy <= 1'b0;
               end
            end
            WAIT_SWAP: begin
               if (frame_done) begin
                  front_sel    <= ~front_sel;
                  swap_pending <= 1'b0;
                  state        <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_hub75_frame_buffer.sv
// Directed self-checking bench for hub75_frame_buffer.
module tb_hub75_frame_buffer;

   localparam int COL_W = 5;
   localparam int ROW_W = 4;

   logic             clk = 1'b0;
   logic             rst;
   logic             wr_valid;
   logic             wr_ready;
   logic [COL_W-1:0] wr_x;
   logic [ROW_W:0]   wr_y;
   logic [2:0]       wr_rgb;
   logic             commit;
   logic             clear;
   logic             swap_pending;
   logic             clear_busy;
   logic             rd_en;
   logic [ROW_W-1:0] rd_row;
   logic [COL_W-1:0] rd_col;
   logic [5:0]       rd_data;
   logic             frame_done;
   logic             front_sel;

   int assertions = 0;
   int failures   = 0;

   hub75_frame_buffer dut (
      .clk          (clk),
      .rst          (rst),
      .wr_valid     (wr_valid),
      .wr_ready     (wr_ready),
      .wr_x         (wr_x),
      .wr_y         (wr_y),
      .wr_rgb       (wr_rgb),
      .commit       (commit),
      .clear        (clear),
      .swap_pending (swap_pending),
      .clear_busy   (clear_busy),
      .rd_en        (rd_en),
      .rd_row       (rd_row),
      .rd_col       (rd_col),
      .rd_data      (rd_data),
      .frame_done   (frame_done),
      .front_sel    (front_sel)
   );

   // Free-running 100 MHz clock
   always #5 clk = ~clk;

   // Compare one observed value against its hand-computed expectation
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      assertions++;
      if (observed !== expected) begin
         failures++;
         $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   // Advance one clock; inputs change and outputs are sampled 1 ns after the edge
   task automatic applyStimulus();
      @(posedge clk);
      #1;
   endtask

   task automatic writePixel(input logic [COL_W-1:0] x, input logic [ROW_W:0] y, input logic [2:0] rgb);
      wr_valid = 1'b1;
      wr_x     = x;
      wr_y     = y;
      wr_rgb   = rgb;
      applyStimulus();
      wr_valid = 1'b0;
   endtask

   task automatic swapBanks();
      commit = 1'b1;
      applyStimulus();
      commit     = 1'b0;
      frame_done = 1'b1;
      applyStimulus();
      frame_done = 1'b0;
   endtask

   task automatic readWord(input logic [ROW_W-1:0] row, input logic [COL_W-1:0] col);
      rd_en  = 1'b1;
      rd_row = row;
      rd_col = col;
      applyStimulus();
      rd_en = 1'b0;
   endtask

   // Count cycles with clear_busy high (bounded) and cycles where wr_ready was wrongly high
   task automatic waitClear(output int busy_cycles, output int ready_bad);
      busy_cycles = 0;
      ready_bad   = 0;
      while (clear_busy && busy_cycles < 1000) begin
         busy_cycles++;
         if (wr_ready) ready_bad++;
         applyStimulus();
      end
   endtask

   // Hard bound on total simulation time
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: observed timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Directed test sequence
   initial begin
      int n;
      int bad;
      int ready_hits;

      rst = 1'b1; wr_valid = 1'b0; wr_x = '0; wr_y = '0; wr_rgb = '0;
      commit = 1'b0; clear = 1'b0; rd_en = 1'b0; rd_row = '0; rd_col = '0; frame_done = 1'b0;
      applyStimulus();
      applyStimulus();
      rst = 1'b0;

      $display("[TB] reset state");
      checkOutput("reset_front_sel", 32'(front_sel), 32'd0);
      checkOutput("reset_rd_data", 32'(rd_data), 32'd0);
      checkOutput("reset_swap_pending", 32'(swap_pending), 32'd0);
      checkOutput("reset_clear_busy", 32'(clear_busy), 32'd0);
      checkOutput("reset_wr_ready", 32'(wr_ready), 32'd1);

      $display("[TB] clear back bank then swap");
      clear = 1'b1;
      applyStimulus();
      clear = 1'b0;
      waitClear(n, bad);
      checkOutput("clear_cycles", 32'(n), 32'd512);
      checkOutput("clear_wr_ready_low", 32'(bad), 32'd0);
      checkOutput("clear_done_wr_ready", 32'(wr_ready), 32'd1);
      commit = 1'b1;
      applyStimulus();
      commit = 1'b0;
      checkOutput("commit_swap_pending", 32'(swap_pending), 32'd1);
      frame_done = 1'b1;
      applyStimulus();
      frame_done = 1'b0;
      checkOutput("swap1_front_sel", 32'(front_sel), 32'd1);
      checkOutput("swap1_pending_drop", 32'(swap_pending), 32'd0);
      readWord(4'd0, 5'd0);
      checkOutput("cleared_r0c0", 32'(rd_data), 32'h00);
      readWord(4'd15, 5'd31);
      checkOutput("cleared_r15c31", 32'(rd_data), 32'h00);
      readWord(4'd7, 5'd12);
      checkOutput("cleared_r7c12", 32'(rd_data), 32'h00);

      $display("[TB] pixel writes, write coincident with commit and frame_done");
      writePixel(5'd5, 5'd3, 3'b100);
      wr_valid = 1'b1; wr_x = 5'd5; wr_y = 5'd19; wr_rgb = 3'b011;
      commit = 1'b1; frame_done = 1'b1;
      applyStimulus();
      wr_valid = 1'b0; commit = 1'b0; frame_done = 1'b0;
      checkOutput("coincident_fd_pending", 32'(swap_pending), 32'd1);
      checkOutput("coincident_fd_front", 32'(front_sel), 32'd1);
      checkOutput("wait_wr_ready", 32'(wr_ready), 32'd0);
      frame_done = 1'b1;
      applyStimulus();
      frame_done = 1'b0;
      checkOutput("swap2_front_sel", 32'(front_sel), 32'd0);
      readWord(4'd3, 5'd5);
      checkOutput("pair_r3c5", 32'(rd_data), 32'b100011);
      rd_row = 4'd0; rd_col = 5'd0;
      applyStimulus();
      checkOutput("rd_data_hold", 32'(rd_data), 32'b100011);

      $display("[TB] writes blocked while waiting for swap");
      commit = 1'b1;
      applyStimulus();
      commit = 1'b0;
      wr_valid = 1'b1; wr_x = 5'd5; wr_y = 5'd3; wr_rgb = 3'b111;
      ready_hits = 0;
      for (int i = 0; i < 10; i++) begin
         if (wr_ready) ready_hits++;
         applyStimulus();
         wr_y = (i % 2 == 0) ? 5'd19 : 5'd3;
      end
      checkOutput("blocked_wr_ready", 32'(ready_hits), 32'd0);
      checkOutput("blocked_front_hold", 32'(front_sel), 32'd0);
      checkOutput("blocked_pending", 32'(swap_pending), 32'd1);
      wr_valid = 1'b0;
      frame_done = 1'b1;
      applyStimulus();
      frame_done = 1'b0;
      checkOutput("swap3_front_sel", 32'(front_sel), 32'd1);
      checkOutput("swap3_pending_drop", 32'(swap_pending), 32'd0);
      readWord(4'd3, 5'd5);
      checkOutput("no_write_landed", 32'(rd_data), 32'h00);

      $display("[TB] clear and commit together");
      clear = 1'b1; commit = 1'b1;
      applyStimulus();
      clear = 1'b0; commit = 1'b0;
      checkOutput("clrcommit_busy", 32'(clear_busy), 32'd1);
      checkOutput("clrcommit_pending", 32'(swap_pending), 32'd0);
      frame_done = 1'b1;
      for (int i = 0; i < 5; i++) applyStimulus();
      frame_done = 1'b0;
      waitClear(n, bad);
      checkOutput("clrcommit_clear_done", 32'(clear_busy), 32'd0);
      for (int i = 0; i < 3; i++) begin
         frame_done = 1'b1;
         applyStimulus();
         frame_done = 1'b0;
         applyStimulus();
      end
      checkOutput("clrcommit_front_hold", 32'(front_sel), 32'd1);
      checkOutput("clrcommit_pending_after", 32'(swap_pending), 32'd0);

      $display("[TB] read coincident with swap");
      writePixel(5'd9, 5'd2, 3'b101);
      writePixel(5'd9, 5'd18, 3'b010);
      swapBanks();
      checkOutput("swap4_front_sel", 32'(front_sel), 32'd0);
      writePixel(5'd9, 5'd2, 3'b010);
      writePixel(5'd9, 5'd18, 3'b101);
      commit = 1'b1;
      applyStimulus();
      commit = 1'b0;
      rd_en = 1'b1; rd_row = 4'd2; rd_col = 5'd9; frame_done = 1'b1;
      applyStimulus();
      frame_done = 1'b0;
      checkOutput("swap_cycle_read_old", 32'(rd_data), 32'h2A);
      checkOutput("swap5_front_sel", 32'(front_sel), 32'd1);
      applyStimulus();
      rd_en = 1'b0;
      checkOutput("post_swap_read_new", 32'(rd_data), 32'h15);

      $display("[TB] reset in the middle of a clear");
      swapBanks();
      checkOutput("swap6_front_sel", 32'(front_sel), 32'd0);
      clear = 1'b1;
      applyStimulus();
      clear = 1'b0;
      for (int i = 0; i < 99; i++) applyStimulus();
      checkOutput("midclear_busy", 32'(clear_busy), 32'd1);
      rst = 1'b1;
      applyStimulus();
      rst = 1'b0;
      checkOutput("abort_wr_ready", 32'(wr_ready), 32'd1);
      checkOutput("abort_clear_busy", 32'(clear_busy), 32'd0);
      checkOutput("abort_front_sel", 32'(front_sel), 32'd0);
      checkOutput("abort_pending", 32'(swap_pending), 32'd0);
      checkOutput("abort_rd_data", 32'(rd_data), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
      $finish;
   end

endmodule

// File: doc/hub75_frame_buffer.md
Name: hub75_frame_buffer

Overview:
- Ping-pong pixel store sitting directly upstream of the HUB75 scan controller.
- A pixel writer fills the back bank through a valid/ready port; the scan controller reads the front bank.
- Each read returns a row-pair word for a column, formatted {R0,G0,B0,R1,G1,B1}.
- Banks swap only at a frame boundary signalled by the scanner, so the panel never shows a half-drawn frame.

Parameters:
- COLS, 32, panel width in pixels (power of 2).
- ROW_PAIRS, 16, scan rows; panel height is 2*ROW_PAIRS and the scanner's row address is A-D.
- COL_W, $clog2(COLS), column index width (derived).
- ROW_W, $clog2(ROW_PAIRS), row-pair index width (derived).

Ports:
- clk  in  1  system clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- wr_valid  in  1  pixel write request.
- wr_ready  out  1  write port can accept a pixel.
- wr_x  in  COL_W  pixel column.
- wr_y  in  ROW_W+1  pixel row; MSB selects lower half.
- wr_rgb  in  3  {R,G,B} for the pixel.
- commit  in  1  pulse: back bank complete, request swap.
- clear  in  1  pulse: zero the entire back bank.
- swap_pending  out  1  commit accepted, waiting for frame_done.
- clear_busy  out  1  clear sweep in progress.
- rd_en  in  1  scanner read strobe.
- rd_row  in  ROW_W  scan row (A-D value).
- rd_col  in  COL_W  column being shifted.
- rd_data  out  6  {R0,G0,B0,R1,G1,B1} of front bank, registered.
- frame_done  in  1  pulse from scanner after last row latched.
- front_sel  out  1  bank currently displayed.

Behaviour:
- Storage: 2 banks, each split into an upper and a lower array of ROW_PAIRS*COLS entries x 3 bits.
  - Index = row*COLS + col.
  - Split halves mean a pixel write never needs read-modify-write.
- Reset values: front_sel=0, state IDLE, rd_data=0, swap_pending=0, clear_busy=0, wr_ready=1. Memory contents are not reset.
- Reset mid-clear or mid-WAIT_SWAP aborts to IDLE. The back bank is left partially cleared and no swap occurs.
- Write handshake:
  - A transfer occurs when wr_valid && wr_ready at a clk edge.
  - The write targets bank ~front_sel.
  - wr_y MSB=0 selects the upper array at row wr_y[ROW_W-1:0]; MSB=1 selects the lower array.
  - wr_ready = (state==IDLE), combinational from state.
- Read path:
  - 1-cycle latency: rd_en sampled at edge N gives rd_data valid after edge N, using the front_sel value at edge N.
  - rd_data holds its value when rd_en=0.
  - Reads of the front bank never stall and are unaffected by writes or clears.
- FSM states: IDLE, CLEAR, WAIT_SWAP.
  - IDLE: clear=1 -> CLEAR, counter=0. Otherwise commit=1 -> WAIT_SWAP. If clear and commit arrive together, clear wins and commit is dropped.
  - IDLE: a write accepted in the same cycle as commit is stored before the swap.
  - IDLE: frame_done is ignored.
  - CLEAR: each cycle writes 0 to upper and lower at index=counter in the back bank, then counter++.
  - CLEAR: after index ROW_PAIRS*COLS-1 (511 by default) -> IDLE, taking exactly 512 cycles.
  - CLEAR: clear_busy=1. commit and clear are ignored.
  - WAIT_SWAP: swap_pending=1.
  - WAIT_SWAP: on frame_done=1, front_sel toggles at that edge -> IDLE. A frame_done coincident with the accepting commit does not count.
  - WAIT_SWAP: clear and commit are ignored.
- A read and the swap in the same cycle: that read uses the old bank; the next read uses the new bank.
- Index arithmetic is unsigned, concatenation {row,col}; COLS a power of 2 means no overflow.

Decomposition:
- Package hub75_pkg holds:
  - COLS and ROW_PAIRS defaults;
  - the fb_state_t enum {IDLE, CLEAR, WAIT_SWAP};
  - the rgb3_t typedef;
  - the rd_data bit-order constants shared with the scan controller.
- Sub-module fb_sdp_ram: simple dual-port RAM, 1 write port, 1 registered read port, 3-bit width, depth ROW_PAIRS*COLS. Instantiated 4 times (2 banks x 2 halves).

Test Plan:
- Reset then clear -> clear_busy high for exactly 512 cycles, wr_ready=0 throughout. Then commit plus frame_done -> front_sel=1, and reading any row/col gives rd_data=6'b000000.
- Write (x=5,y=3,rgb=3'b100) and (x=5,y=19,rgb=3'b011), commit, frame_done -> read row=3 col=5 gives 6'b100011 one cycle after rd_en.
- Commit, then hold wr_valid for 10 cycles before frame_done -> wr_ready=0 and no writes land. Swap occurs only on the frame_done edge, and swap_pending drops the next cycle.
- clear and commit in the same IDLE cycle -> CLEAR entered, swap_pending stays 0, front_sel unchanged after any number of frame_done pulses.
- rd_en at the swap cycle and the next cycle, with banks holding 6'h2A vs 6'h15 at the same address -> rd_data = 6'h2A then 6'h15.
- rst asserted at clear cycle 100 -> next cycle state IDLE, clear_busy=0, wr_ready=1, front_sel retains 0.
